data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data RAM address width (matches the 256-word data RAM).
REQ-002 SHALL have parameter LOCK_MAX, default 8, maximum consecutive locked debug grants.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetGral  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pReq  input  1  pipeline MEM-stage access request.
REQ-006 SHALL have port pWe  input  4  pipeline byte write enables; 0 = read.
REQ-007 SHALL have port pAddr  input  ADDR_W  pipeline word address.
REQ-008 SHALL have port pWdata  input  32  pipeline write data.
REQ-009 SHALL have port pStall  output  1  pipeline request not served this cycle; freeze IF/ID/EX/MEM.
REQ-010 SHALL have port pRdata  output  32  read data to pipeline.
REQ-011 SHALL have port pValid  output  1  pRdata valid.
REQ-012 SHALL have ports dReq/dWe/dAddr/dWdata  input  1/4/ADDR_W/32  debug-port request, mirroring the pipeline port.
REQ-013 SHALL have port dLock  input  1  debug requests a locked burst.
REQ-014 SHALL have ports dGnt/dRdata/dValid  output  1/32/1  debug grant, read data, read-data valid.
REQ-015 SHALL have ports ramWe/ramAddr/ramDin  output  4/ADDR_W/32  RAM port (wea/addra/dina).
REQ-016 SHALL have port ramDout  input  32  RAM douta; synchronous, 1-cycle read latency.

Function
REQ-017 SHALL issue at most one access to the RAM per cycle; the grant is combinational and the RAM is driven by the winner in the same cycle.
REQ-018 Single requester: that requester SHALL win.
REQ-019 Both requesting, no lock active: winner SHALL be chosen per REQ-034/035.
REQ-020 No winner: ramWe SHALL be 0 and ramAddr/ramDin 0; dGnt SHALL be 0.
REQ-021 pStall SHALL be pReq AND NOT pipeline-granted; dGnt SHALL be high only in cycles where debug wins.
REQ-022 FSM states: IDLE, PIPE, DBG, DBG_LOCK; the state register holds last cycle's owner.
REQ-023 DBG/DBG_LOCK with dLock=1 and dReq=1 SHALL give debug the grant regardless of pReq; lockCnt increments per locked grant.
REQ-024 When lockCnt reaches LOCK_MAX with pReq=1, the next cycle SHALL grant the pipeline and clear lockCnt; with pReq=0 the lock continues and lockCnt saturates.
REQ-025 dLock or dReq low SHALL release the lock and clear lockCnt in the same cycle.
REQ-026 A granted read (We=0) SHALL set a 1-entry tag register {valid, owner}; the next cycle pValid or dValid (per owner) SHALL be 1 for exactly one cycle.
REQ-027 pRdata and dRdata SHALL both be ramDout passthrough; only the valid flags are qualified.
REQ-028 Granted writes SHALL produce no valid pulse.
REQ-029 Back-to-back reads by alternating owners SHALL each produce their valid pulse in order, one per cycle.
REQ-030 Requester inputs SHALL be sampled only in the cycle they are granted; an ungranted requester SHALL hold its request stable.

Reset
REQ-031 Asserting resetGral SHALL immediately force state=IDLE, lockCnt=0, tag valid=0, lastGnt=debug.
REQ-032 During reset, pValid=dValid=0, ramWe=0, dGnt=0, pStall=pReq.
REQ-033 A read in flight at reset SHALL be dropped; no valid pulse after release.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined, on contention the requester not granted most recently (lastGnt) SHALL win; lastGnt resets to debug, so the pipeline wins the first contention.
REQ-035 Without ARB_ROUND_ROBIN_EN, the pipeline SHALL always win contention outside a lock; debug is served only when pReq=0 or while locked.

Verification
REQ-036 pReq=1, pWe=0, pAddr=0x10, RAM[0x10]=0xDEADBEEF, dReq=0 -> pStall=0, ramAddr=0x10, next cycle pValid=1, pRdata=0xDEADBEEF.
REQ-037 Both request 4 cycles, dLock=0, round-robin defined -> grants P,D,P,D; pStall=1 in cycles 2 and 4; undefined -> P every cycle, dGnt=0.
REQ-038 dLock=1, dReq=1, pReq=1 held 12 cycles after debug first wins -> 8 consecutive dGnt, then 1 pipeline grant, then lock resumes.
REQ-039 dWe=4'b0011, dAddr=0x20, dWdata=0x0000ABCD granted -> ramWe=4'b0011 that cycle, no dValid next cycle.
REQ-040 Debug read granted, resetGral pulsed before next edge -> dValid stays 0, state IDLE, next contention granted to pipeline.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbitrates the pipeline MEM stage and the debug port onto one single-port data RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default build gives the pipeline fixed priority.
module data_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic              clock,
  input  logic              resetGral,
  input  logic              pReq,
  input  logic [3:0]        pWe,
  input  logic [ADDR_W-1:0] pAddr,
  input  logic [31:0]       pWdata,
  output logic              pStall,
  output logic [31:0]       pRdata,
  output logic              pValid,
  input  logic              dReq,
  input  logic [3:0]        dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [31:0]       dWdata,
  input  logic              dLock,
  output logic              dGnt,
  output logic [31:0]       dRdata,
  output logic              dValid,
  output logic [3:0]        ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [31:0]       ramDin,
  input  logic [31:0]       ramDout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, PIPE, DBG, DBG_LOCK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] lockCnt_q, lockCnt_d;
  logic          yield_q, yield_d;
  logic          lastGntDbg_q, lastGntDbg_d;
  logic          tagV_q, tagV_d;
  logic          tagDbg_q, tagDbg_d;
  logic          gntP, gntD, lockOn;

  always_ff @(posedge clock or posedge resetGral) begin
    if (resetGral) begin
      state_q      <= IDLE;
      lockCnt_q    <= '0;
      yield_q      <= 1'b0;
      lastGntDbg_q <= 1'b1;
      tagV_q       <= 1'b0;
      tagDbg_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lockCnt_q    <= lockCnt_d;
      yield_q      <= yield_d;
      lastGntDbg_q <= lastGntDbg_d;
      tagV_q       <= tagV_d;
      tagDbg_q     <= tagDbg_d;
    end
  end

  always_comb begin
    gntP         = 1'b0;
    gntD         = 1'b0;
    lockCnt_d    = '0;
    yield_d      = 1'b0;
    state_d      = IDLE;
    lastGntDbg_d = lastGntDbg_q;
    tagV_d       = 1'b0;
    tagDbg_d     = 1'b0;
    // A lock survives the single forced pipeline slot via yield_q.
    lockOn = dReq && dLock && (state_q == DBG || state_q == DBG_LOCK || yield_q);
    if (lockOn) begin
      if (lockCnt_q == CNT_MAX && pReq) begin
        gntP    = 1'b1;
        yield_d = 1'b1;
      end else begin
        gntD      = 1'b1;
        lockCnt_d = (lockCnt_q == CNT_MAX) ? lockCnt_q : lockCnt_q + 1'b1;
      end
    end else if (pReq && dReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      gntP = lastGntDbg_q;
      gntD = !lastGntDbg_q;
`else
      gntP = 1'b1;
`endif
    end else begin
      gntP = pReq;
      gntD = dReq;
    end
    if (!lockOn && gntD && dLock) lockCnt_d = CW'(1);
    if (resetGral) begin
      gntP = 1'b0;
      gntD = 1'b0;
    end
    if (gntP) begin
      state_d      = PIPE;
      lastGntDbg_d = 1'b0;
      tagV_d       = (pWe == 4'b0);
    end else if (gntD) begin
      state_d      = dLock ? DBG_LOCK : DBG;
      lastGntDbg_d = 1'b1;
      tagV_d       = (dWe == 4'b0);
      tagDbg_d     = 1'b1;
    end
  end

  assign ramWe   = gntP ? pWe    : (gntD ? dWe    : 4'b0);
  assign ramAddr = gntP ? pAddr  : (gntD ? dAddr  : '0);
  assign ramDin  = gntP ? pWdata : (gntD ? dWdata : 32'b0);

  assign pStall = pReq & ~gntP;
  assign dGnt   = gntD;
  assign pRdata = ramDout;
  assign dRdata = ramDout;
  assign pValid = tagV_q & ~tagDbg_q;
  assign dValid = tagV_q & tagDbg_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int AW = 8;
  localparam int LM = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetGral = 1'b1;
  logic          pReq = 0, dReq = 0, dLock = 0;
  logic [3:0]    pWe = 0, dWe = 0;
  logic [AW-1:0] pAddr = 0, dAddr = 0;
  logic [31:0]   pWdata = 0, dWdata = 0;
  logic          pStall, pValid, dGnt, dValid;
  logic [31:0]   pRdata, dRdata, ramDin, ramDout;
  logic [3:0]    ramWe;
  logic [AW-1:0] ramAddr;
  logic          ramInit = 1'b1;

  data_mem_arbiter #(.ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clock(clock), .resetGral(resetGral),
    .pReq(pReq), .pWe(pWe), .pAddr(pAddr), .pWdata(pWdata),
    .pStall(pStall), .pRdata(pRdata), .pValid(pValid),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dLock(dLock),
    .dGnt(dGnt), .dRdata(dRdata), .dValid(dValid),
    .ramWe(ramWe), .ramAddr(ramAddr), .ramDin(ramDin), .ramDout(ramDout)
  );

  function automatic logic [31:0] init_word(int a);
    if (a == 16) return 32'hDEADBEEF;
    return (32'(a) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  logic [31:0] ram [256];
  always @(posedge clock) begin
    if (ramInit) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (ramWe[b]) ram[ramAddr][8*b +: 8] <= ramDin[8*b +: 8];
    end
    ramDout <= ram[ramAddr];
  end

  // Behavioural model: who won last cycle, length of the current locked run,
  // whether the last pipeline slot was a forced yield, and the pending read.
  logic [31:0] refMem [256];
  int          m_prev;      // 0 none, 1 pipeline, 2 debug
  bit          m_yield;
  int          m_run;
  bit          m_lastD;
  bit          m_tagV, m_tagD;
  logic [31:0] m_tagData;
  int          errCnt = 0;
  int          chkCnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_yield = 0; m_run = 0; m_lastD = 1;
    m_tagV = 0; m_tagD = 0; m_tagData = 0;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(output bit g);
    int win;
    bit lock, forced;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    #1;
    forced = 0;
    lock = dReq && dLock && (m_prev == 2 || m_yield);
    if (lock) begin
      if (m_run >= LM && pReq) begin win = 1; forced = 1; end
      else win = 2;
    end else if (pReq && dReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = m_lastD ? 1 : 2;
`else
      win = 1;
`endif
    end else win = pReq ? 1 : (dReq ? 2 : 0);
    we = (win == 1) ? pWe    : (win == 2) ? dWe    : 4'b0;
    a  = (win == 1) ? pAddr  : (win == 2) ? dAddr  : '0;
    wd = (win == 1) ? pWdata : (win == 2) ? dWdata : 32'b0;
    g = dGnt;
    check("dGnt",    32'(dGnt),    32'(win == 2));
    check("pStall",  32'(pStall),  32'(pReq && win != 1));
    check("ramWe",   32'(ramWe),   32'(we));
    check("ramAddr", 32'(ramAddr), 32'(a));
    check("ramDin",  ramDin,       wd);
    check("pValid",  32'(pValid),  32'(m_tagV && !m_tagD));
    check("dValid",  32'(dValid),  32'(m_tagV && m_tagD));
    if (m_tagV) check(m_tagD ? "dRdata" : "pRdata", m_tagD ? dRdata : pRdata, m_tagData);
    @(posedge clock);
    m_tagV = (win != 0) && (we == 4'b0);
    m_tagD = (win == 2);
    m_tagData = refMem[a];
    for (int b = 0; b < 4; b++)
      if (we[b]) refMem[a][8*b +: 8] = wd[8*b +: 8];
    if (lock) m_run = forced ? 0 : ((m_run >= LM) ? LM : m_run + 1);
    else      m_run = (win == 2 && dLock) ? 1 : 0;
    m_yield = forced;
    m_prev = win;
    if (win != 0) m_lastD = (win == 2);
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetGral = 1; pReq = 1; dReq = 1; pWe = 0; dWe = 0; dLock = 0;
    #1;
    check("rst_dGnt",   32'(dGnt),   32'd0);
    check("rst_ramWe",  32'(ramWe),  32'd0);
    check("rst_pStall", 32'(pStall), 32'd1);
    check("rst_pValid", 32'(pValid), 32'd0);
    check("rst_dValid", 32'(dValid), 32'd0);
    @(negedge clock);
    resetGral = 0; pReq = 0; dReq = 0;
    model_reset();
  endtask

  bit g;
  bit seq [13];
  int run;

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = init_word(i);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    ramInit = 0;
    do_reset();

    // Pipeline read of a known word.
    pReq = 1; pWe = 0; pAddr = 8'h10;
    step(g);
    #1 check("p_read_data", pRdata, 32'hDEADBEEF);
    check("p_read_valid", 32'(pValid), 32'd1);
    pReq = 0;
    step(g);

    // Four cycles of plain contention from reset.
    do_reset();
    pReq = 1; pWe = 0; pAddr = 8'h11; dReq = 1; dWe = 0; dAddr = 8'h12; dLock = 0;
    run = 0;
    for (int i = 0; i < 4; i++) begin
      step(g);
      run = run | (int'(g) << i);
    end
`ifdef ARB_ROUND_ROBIN_EN
    check("contend_pattern", 32'(run), 32'b1010);
`else
    check("contend_pattern", 32'(run), 32'b0000);
`endif
    pReq = 0; dReq = 0;
    step(g);

    // Locked burst: debug wins alone, then the pipeline keeps requesting.
    dReq = 1; dLock = 1; dWe = 0; dAddr = 8'h40;
    step(seq[0]);
    pReq = 1; pAddr = 8'h41;
    for (int i = 1; i < 13; i++) step(seq[i]);
    run = 0;
    while (run < 13 && seq[run]) run++;
    check("lock_run", 32'(run), 32'(LM));
    check("lock_resume", 32'(seq[LM+1]), 32'd1);
    pReq = 0; dReq = 0; dLock = 0;
    step(g);

    // Debug partial write: no read-valid pulse follows.
    dReq = 1; dWe = 4'b0011; dAddr = 8'h20; dWdata = 32'h0000ABCD;
    #1 check("dbg_write_we", 32'(ramWe), 32'b0011);
    step(g);
    dReq = 0; dWe = 0;
    step(g);

    // Debug read dropped by a reset before its data returns.
    dReq = 1; dWe = 0; dAddr = 8'h30; dLock = 0; pReq = 0;
    #1 check("inflight_dGnt", 32'(dGnt), 32'd1);
    #2 resetGral = 1;
    #1 check("inflight_dGnt_rst", 32'(dGnt), 32'd0);
    check("inflight_ramWe_rst", 32'(ramWe), 32'd0);
    @(negedge clock);
    resetGral = 0; dReq = 0;
    model_reset();
    step(g);
    check("inflight_dValid", 32'(dValid), 32'd0);
    pReq = 1; pWe = 0; pAddr = 8'h31; dReq = 1; dAddr = 8'h32;
    step(g);
    check("post_rst_contend", 32'(g), 32'd0);
    pReq = 0; dReq = 0;
    step(g);

    // Random traffic; an ungranted requester holds its request.
    for (int c = 0; c < 400; c++) begin
      if (!(pReq && m_prev != 1)) begin
        pReq   = ($urandom_range(0, 9) < 6);
        pWe    = $urandom_range(0, 1) ? 4'b0 : 4'($urandom_range(1, 15));
        pAddr  = AW'($urandom);
        pWdata = $urandom;
      end
      if (!(dReq && m_prev != 2)) begin
        if ($urandom_range(0, 9) == 0) dLock = ~dLock;
        dReq   = dLock ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
        dWe    = $urandom_range(0, 1) ? 4'b0 : 4'($urandom_range(1, 15));
        dAddr  = AW'($urandom);
        dWdata = $urandom;
      end
      step(g);
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
